// File: rtl/pwm_duty_capture.sv
// pwm_duty_capture: measures the high time of three PWM inputs over 256-tick windows.
// Optional 3-sample majority glitch filter on each input: define PWM_CAP_GLITCH_FILTER_EN.
module pwm_duty_capture #(
  parameter int unsigned CLK_DIV     = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       R_in,
  input  logic       G_in,
  input  logic       B_in,
  output logic [7:0] R_time_out,
  output logic [7:0] G_time_out,
  output logic [7:0] B_time_out,
  output logic       valid_out
);

  localparam int unsigned NCH   = 3;
  localparam int unsigned PRE_W = 16;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned ACC_W = 9;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t           r_state;
  logic [PRE_W-1:0] r_pre;
  logic [IDX_W-1:0] r_idx;
  logic             r_upd;
  logic             r_valid;

  logic [NCH-1:0]   w_in;
  logic [NCH-1:0]   w_s;
  logic             w_tick;
  logic             w_last;

  assign w_in   = {B_in, G_in, R_in};
  assign w_tick = en && (r_pre == PRE_MAX);
  assign w_last = w_tick && (r_idx == {IDX_W{1'b1}});

  // Window sequencing: prescaler, tick index and the one-cycle update strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_pre   <= '0;
      r_idx   <= '0;
      r_upd   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_upd   <= w_last;
      r_valid <= r_upd;
      case (r_state)
        ST_IDLE: if (en)  r_state <= ST_RUN;
        ST_RUN:  if (!en) r_state <= ST_IDLE;
        default:          r_state <= ST_IDLE;
      endcase
      if (en) begin
        r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
        if (w_tick) r_idx <= r_idx + IDX_W'(1);
      end else if (r_state == ST_RUN) begin
        r_pre <= '0;
        r_idx <= '0;
      end
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic [ACC_W-1:0]       r_acc;
    logic [7:0]             r_time;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sync <= '0;
      else     r_sync <= {r_sync[SYNC_STAGES-2:0], w_in[c]};
    end

`ifdef PWM_CAP_GLITCH_FILTER_EN
    logic w_sync_out;
    logic r_h1;
    logic r_h2;

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_h1 <= 1'b0;
        r_h2 <= 1'b0;
      end else begin
        r_h1 <= w_sync_out;
        r_h2 <= r_h1;
      end
    end

    // Majority of the last three synchronized samples rejects 1-cycle pulses and dropouts.
    assign w_s[c] = (w_sync_out & r_h1) | (w_sync_out & r_h2) | (r_h1 & r_h2);
`else
    assign w_s[c] = r_sync[SYNC_STAGES-1];
`endif

    // The update cycle clears the accumulator but still counts a tick landing on it.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_acc  <= '0;
        r_time <= '0;
      end else begin
        if (r_upd) r_time <= r_acc[ACC_W-1] ? 8'hFF : r_acc[7:0];
        if (en) begin
          r_acc <= (r_upd ? '0 : r_acc) + ACC_W'(w_tick && w_s[c]);
        end else if (r_state == ST_RUN) begin
          r_acc <= '0;
        end
      end
    end
  end

  assign R_time_out = g_ch[0].r_time;
  assign G_time_out = g_ch[1].r_time;
  assign B_time_out = g_ch[2].r_time;
  assign valid_out  = r_valid;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: window-level behavioural model checked every cycle,
// plus directed scenarios with hand-computed results (CLK_DIV=2, SYNC_STAGES=2).
module tb_pwm_duty_capture;

  localparam int CLK_DIV = 2;
  localparam int SYNC    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic       R_in = 1'b0;
  logic       G_in = 1'b0;
  logic       B_in = 1'b0;
  logic [7:0] R_time_out;
  logic [7:0] G_time_out;
  logic [7:0] B_time_out;
  logic       valid_out;

  always #5 clk = ~clk;

  pwm_duty_capture #(
    .CLK_DIV     (CLK_DIV),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .R_in       (R_in),
    .G_in       (G_in),
    .B_in       (B_in),
    .R_time_out (R_time_out),
    .G_time_out (G_time_out),
    .B_time_out (B_time_out),
    .valid_out  (valid_out)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp = n_cmp + 1;
    if (act != exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: p counts enabled clock edges since capture (re)start; a tick falls on every
  // CLK_DIV-th edge, 256 ticks make a window, and the result appears one edge later.
  // The value seen at edge e is the pin value captured SYNC edges earlier.
  wire [2:0] tb_in = {B_in, G_in, R_in};
  bit  [5:0] m_hist [3] = '{6'd0, 6'd0, 6'd0};
  int        m_p = 0;
  int        m_cnt [3] = '{0, 0, 0};
  int        m_done [3] = '{0, 0, 0};
  int        m_out [3] = '{0, 0, 0};
  bit        m_pend = 1'b0;
  bit        m_valid = 1'b0;

  wire m_tick = en && ((m_p % CLK_DIV) == CLK_DIV - 1);
  wire m_last = m_tick && (((m_p / CLK_DIV) % 256) == 255);

  function automatic int samp(input bit [5:0] h);
`ifdef PWM_CAP_GLITCH_FILTER_EN
    return (int'(h[SYNC]) + int'(h[SYNC+1]) + int'(h[SYNC+2])) >= 2 ? 1 : 0;
`else
    return int'(h[SYNC]);
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_hist[c] <= '0;
        m_cnt[c]  <= 0;
        m_done[c] <= 0;
        m_out[c]  <= 0;
      end
      m_p     <= 0;
      m_pend  <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        m_hist[c] <= {m_hist[c][4:0], tb_in[c]};
        if (!en)
          m_cnt[c] <= 0;
        else if (m_last) begin
          m_done[c] <= m_cnt[c] + samp({m_hist[c][4:0], tb_in[c]});
          m_cnt[c]  <= 0;
        end else if (m_tick)
          m_cnt[c] <= m_cnt[c] + samp({m_hist[c][4:0], tb_in[c]});
        if (m_pend) m_out[c] <= (m_done[c] > 255) ? 255 : m_done[c];
      end
      m_valid <= m_pend;
      m_pend  <= m_last;
      m_p     <= en ? m_p + 1 : 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_valid", int'(valid_out), int'(m_valid));
    check("model_R", int'(R_time_out), m_out[0]);
    check("model_G", int'(G_time_out), m_out[1]);
    check("model_B", int'(B_time_out), m_out[2]);
  end

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n = n + 1;
      if (valid_out) return;
      if (n >= budget) begin
        n_cmp  = n_cmp + 1;
        n_fail = n_fail + 1;
        $display("FAIL wait_valid: no valid_out within %0d cycles (t=%0t)", budget, $time);
        n = -1;
        return;
      end
    end
  endtask

  int  phase   = 0;
  bit  arm_en  = 1'b0;
  int  n_valid = 0;

  // One clock of the 512-clk PWM source: R 256, G 64, B 2 clocks high.
  task automatic pwm_step();
    @(negedge clk);
    if (valid_out) begin
      n_valid = n_valid + 1;
      check("pwm_R", int'(R_time_out), 128);
      check("pwm_G", int'(G_time_out), 32);
      check("pwm_B", int'(B_time_out), 1);
    end
    if (arm_en && phase == 0) en = 1'b1;
    R_in  = (phase < 256);
    G_in  = (phase < 64);
    B_in  = (phase < 2);
    phase = (phase + 1) % 512;
  endtask

  int n;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_R", int'(R_time_out), 0);
    check("rst_G", int'(G_time_out), 0);
    check("rst_B", int'(B_time_out), 0);
    check("rst_valid", int'(valid_out), 0);
    rst = 1'b0;

    // All inputs low: zero results every 512 clocks.
    en = 1'b1;
    wait_valid(600, n);
    check("t1_first_latency", n, 513);
    wait_valid(600, n);
    check("t1_period", n, 512);
    check("t1_R", int'(R_time_out), 0);
    check("t1_G", int'(G_time_out), 0);
    check("t1_B", int'(B_time_out), 0);

    // Constant-high red saturates at 255.
    R_in = 1'b1;
    wait_valid(600, n);
    wait_valid(600, n);
    check("t2_period", n, 512);
    check("t2_R_sat", int'(R_time_out), 255);
    check("t2_G", int'(G_time_out), 0);
    check("t2_B", int'(B_time_out), 0);

    // en dropped for 10 cycles after tick 100, then red constant high.
    @(negedge clk);
    en = 1'b0; R_in = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (202) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t4_no_valid_en_low", int'(valid_out), 0);
    end
    R_in = 1'b1; en = 1'b1;
    wait_valid(600, n);
    check("t4_latency", n, 513);
    check("t4_R", int'(R_time_out), 255);
    check("t4_G", int'(G_time_out), 0);

    // PWM source aligned to en rise: 128/32/1 in the first and following windows.
    @(negedge clk);
    en = 1'b0; R_in = 1'b0;
    phase = 508; arm_en = 1'b1; n_valid = 0;
    repeat (1104) pwm_step();
    check("t3_nvalid", n_valid, 2);
    arm_en = 1'b0;

    // Asynchronous reset mid-window clears the held 128/32/1 result at once.
    check("t5_pre_R", int'(R_time_out), 128);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_async_R", int'(R_time_out), 0);
    check("t5_async_G", int'(G_time_out), 0);
    check("t5_async_B", int'(B_time_out), 0);
    check("t5_async_valid", int'(valid_out), 0);
    @(negedge clk);
    rst = 1'b0; R_in = 1'b0; G_in = 1'b0; B_in = 1'b0;
    wait_valid(600, n);
    check("t5_latency", n, 513);
    check("t5_R", int'(R_time_out), 0);

    // Single 1-clk green pulse that the sampler sees on tick edge 11.
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    repeat (9) @(negedge clk);
    G_in = 1'b1;
    @(negedge clk);
    G_in = 1'b0;
    wait_valid(600, n);
`ifdef PWM_CAP_GLITCH_FILTER_EN
    check("t6_G_pulse", int'(G_time_out), 0);
`else
    check("t6_G_pulse", int'(G_time_out), 1);
`endif
    check("t6_R", int'(R_time_out), 0);
    check("t6_B", int'(B_time_out), 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_duty_capture.md
Name: pwm_duty_capture

Overview:
- Receive-side counterpart of the RGB PWM generator.
- Samples three PWM waveforms (R, G, B) and measures each channel's high time over a fixed 256-tick window.
- Reports the result as 8-bit time values in the same encoding the generator consumes.
- Used for loopback self-check of the LED driver and for decoding externally supplied PWM colour commands.

Parameters:
- CLK_DIV, 1000, clk cycles per PWM tick; legal range 1..65535.
- SYNC_STAGES, 2, synchronizer flops on each PWM input; legal range 2..3.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- en  input  1  capture enable; low holds the window in its start state
- R_in  input  1  red PWM waveform, asynchronous to clk
- G_in  input  1  green PWM waveform, asynchronous to clk
- B_in  input  1  blue PWM waveform, asynchronous to clk
- R_time_out  output  8  measured red high time, in ticks
- G_time_out  output  8  measured green high time, in ticks
- B_time_out  output  8  measured blue high time, in ticks
- valid_out  output  1  one-cycle pulse when the *_time_out outputs update

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - All outputs 0.
  - Prescaler, tick index, accumulators and synchronizers all 0.
- Input sync: each *_in passes through SYNC_STAGES flops. The synchronized value is s_x.
- Prescaler:
  - Counts 0..CLK_DIV-1, then wraps.
  - tick is asserted on the cycle the prescaler equals CLK_DIV-1.
- Tick index: 8-bit counter that increments on tick and wraps 255 -> 0. One window is 256 ticks.
- Accumulate: on each tick, each channel's 9-bit accumulator increments if its s_x = 1.
- Window end: on the tick where the index is 255:
  - The sample at index 255 is included in the accumulators.
  - Next cycle, each *_time_out = min(acc, 255) and valid_out = 1 for exactly one cycle.
  - On that same next cycle, all accumulators clear to 0.
- Saturation: 256 high samples (a constant-high input) report 255. No wrap to 0.
- Output hold: *_time_out keep their last value between updates.
- en = 0:
  - Prescaler, tick index and accumulators are forced to 0.
  - valid_out = 0; outputs hold.
  - Capture restarts at index 0 on the first cycle with en = 1.
- en falling on the window-end tick: the update in the following cycle still occurs.
- rst mid-window: async clear of everything, including outputs. No partial result is ever reported.
- State machine: two states.
  - IDLE (en = 0) -> RUN when en = 1.
  - RUN -> IDLE when en = 0.
  - Window-end update is a registered action within RUN.
- Latency: input edge to first affected sample = SYNC_STAGES cycles, plus 1 more with the filter enabled.

Optional Feature:
- Macro: PWM_CAP_GLITCH_FILTER_EN.
- Defined:
  - Each s_x is replaced by the 3-sample majority of its last three synchronized clk-cycle values.
  - Any isolated 1-cycle pulse or dropout is rejected.
  - Adds 1 cycle of input latency.
- Undefined: s_x is used directly; a 1-cycle pulse that lands on a tick cycle is counted.

Test Plan (CLK_DIV=2, SYNC_STAGES=2 unless noted):
1. All inputs held 0, en = 1 -> valid_out pulses every 512 clk; outputs R/G/B = 0/0/0.
2. R_in constant 1, G_in/B_in constant 0 -> R_time_out = 255 (saturated), G/B = 0. Check valid_out period = 512 cycles.
3. PWM source with period 512 clk; R high 256 clk, G high 64 clk, B high 2 clk, aligned to en rise -> first window reports 128/32/1. Steady state repeats the same values each window.
4. en dropped for 10 cycles at tick 100, then R constant 1 -> no valid_out while en is low. Next valid_out arrives 512 cycles after en rises and reports R = 255.
5. rst pulsed mid-window after a prior result of 128 -> outputs 0 immediately (asynchronous). First new valid_out comes 512 cycles after rst deasserts.
6. Single 1-clk G_in pulse aligned to a tick sample:
   - Filter undefined -> G_time_out = 1.
   - PWM_CAP_GLITCH_FILTER_EN defined -> G_time_out = 0.
